accumulate_n: RTL

ACCUMULATE_N -- requirements
Module: accumulate_n

---
 rtl/accumulate_n.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/accumulate_n.sv
// accumulate_n: sums a window of N accepted samples, or a shorter window cut
// off by flush, and presents the (optionally saturated) sum through a
// valid/ready output register that holds until downstream takes it.
module accumulate_n #(
    parameter int DATA_W   = 32,
    parameter int N        = 15,
    parameter int ACC_W    = 36,
    parameter bit SIGNED   = 1'b0,
    parameter bit SATURATE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mult_valid,
    output logic                   mult_ready,
    input  logic [DATA_W-1:0]      mult_data,
    input  logic                   flush,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      data_out,
    output logic                   valid_out,
    output logic [$clog2(N+1)-1:0] count_out,
    output logic                   sat_out
);

    localparam int CNT_W = $clog2(N+1);
    // One guard bit above the accumulator so the range slices below are
    // never empty, even when ACC_W equals DATA_W.
    localparam int EXT_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t              state_q;
    logic                rdyEn_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   data_d;
    logic [CNT_W-1:0]    count_q;
    logic                sat_q;
    logic                sat_d;
    logic                accept;
    logic                emit;
    logic [ACC_W-1:0]    sampleExt;
    logic [EXT_W-1:0]    sumExt;
    logic [EXT_W-DATA_W-1:0] upperBits;
    logic [EXT_W-DATA_W:0]   signBits;
    logic [DATA_W-1:0]   clampVal;

    // rdyEn_q keeps mult_ready low until the first edge after reset;
    // in HOLD a new sample is only taken when the held result leaves.
    assign mult_ready = rdyEn_q & ((state_q == ACCUM) | out_ready);
    assign accept     = mult_valid & mult_ready;
    assign valid_out  = (state_q == HOLD);
    assign data_out   = data_q;
    assign count_out  = count_q;
    assign sat_out    = sat_q;

    // Next sum and count, range detection and the value to emit.
    always_comb begin
        sampleExt = '0;
        sampleExt[DATA_W-1:0] = mult_data;
        for (int i = DATA_W; i < ACC_W; i++) begin
            sampleExt[i] = SIGNED & mult_data[DATA_W-1];
        end

        acc_d = accept ? (acc_q + sampleExt) : acc_q;
        cnt_d = cnt_q + CNT_W'(accept);

        sumExt    = {SIGNED & acc_d[ACC_W-1], acc_d};
        upperBits = sumExt[EXT_W-1:DATA_W];
        signBits  = sumExt[EXT_W-1:DATA_W-1];

        if (SIGNED) begin
            sat_d = !((&signBits) || !(|signBits));
        end else begin
            sat_d = |upperBits;
        end

        clampVal = '1;
        for (int i = 0; i < DATA_W; i++) begin
            if (SIGNED) begin
                clampVal[i] = (i == DATA_W-1) ? sumExt[EXT_W-1] : ~sumExt[EXT_W-1];
            end
        end

        data_d = (SATURATE && sat_d) ? clampVal : acc_d[DATA_W-1:0];

        emit = 1'b0;
        if (state_q == ACCUM) begin
            emit = (accept && (cnt_d == N_CNT)) || (flush && ((cnt_q != '0) || accept));
        end else begin
            emit = out_ready && accept && (cnt_d == N_CNT);
        end
    end

    // Window FSM: accumulate, load the output register on emission, and
    // hold it until downstream accepts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            rdyEn_q <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            rdyEn_q <= 1'b1;
            case (state_q)
                ACCUM: begin
                    if (emit) begin
                        data_q  <= data_d;
                        count_q <= cnt_d;
                        sat_q   <= sat_d;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= HOLD;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (emit) begin
                            data_q  <= data_d;
                            count_q <= cnt_d;
                            sat_q   <= sat_d;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                        end else begin
                            acc_q   <= acc_d;
                            cnt_q   <= cnt_d;
                            state_q <= ACCUM;
                        end
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

endmodule
